// File: rtl/key_scan_if.sv
// Signal bundle between the keypad scanner and the board matrix / application logic.
// master = scanner side (drives rows and key reports), slave = matrix/consumer side.
interface key_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/key_scan.sv
// 4x4 matrix-keypad scanner: one row low per slot, columns read back, frames debounced.
// state     | meaning
// IDLE      | no key accepted, waiting for a hit frame
// PRESS_DEB | counting consecutive frames with the same candidate code
// HELD      | press accepted, key_down high
// REL_DEB   | counting consecutive empty frames before release
module key_scan #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic       CLK,
    input  logic       RST,
    key_scan_if.master kif
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_N    = 8'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  col_m_q, col_s_q;
    logic [15:0] div_q, div_d;
    logic [1:0]  r_q, r_d;
    logic        hit_q, hit_d;
    logic [3:0]  code_q, code_d;
    logic [3:0]  cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_down_q, key_down_d;

    logic        tick;
    logic        frame_done;
    logic [3:0]  col_low;
    logic        any_low;
    logic [1:0]  col_idx;
    logic        frame_hit;
    logic [3:0]  frame_code;
    logic [7:0]  cnt_inc;

    always_comb begin
        col_low = ~col_s_q;
        any_low = |col_low;
        col_idx = 2'd0;
        if (col_low[0])      col_idx = 2'd0;
        else if (col_low[1]) col_idx = 2'd1;
        else if (col_low[2]) col_idx = 2'd2;
        else if (col_low[3]) col_idx = 2'd3;

        tick       = (div_q == DIV_LAST);
        frame_done = tick && (r_q == 2'd3);
        // An earlier row already latched wins, which gives the lowest code overall.
        frame_hit  = hit_q | any_low;
        frame_code = hit_q ? code_q : {2'd3, col_idx};
        cnt_inc    = cnt_q + 8'd1;

        div_d       = tick ? 16'd0 : div_q + 16'd1;
        r_d         = tick ? r_q + 2'd1 : r_q;
        hit_d       = hit_q;
        code_d      = code_q;
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;

        if (tick) begin
            if (r_q != 2'd3) begin
                if (!hit_q && any_low) begin
                    hit_d  = 1'b1;
                    code_d = {r_q, col_idx};
                end
            end else begin
                hit_d  = 1'b0;
                code_d = 4'd0;
            end
        end

        if (frame_done) begin
            case (state_q)
                IDLE: begin
                    if (frame_hit) begin
                        cand_d  = frame_code;
                        cnt_d   = 8'd1;
                        state_d = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (frame_hit && (frame_code == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (!frame_hit) begin
                        cnt_d   = 8'd1;
                        state_d = REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (frame_hit) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            key_down_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_m_q     <= 4'hF;
            col_s_q     <= 4'hF;
            div_q       <= 16'd0;
            r_q         <= 2'd0;
            hit_q       <= 1'b0;
            code_q      <= 4'd0;
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 8'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            col_m_q     <= kif.col;
            col_s_q     <= col_m_q;
            div_q       <= div_d;
            r_q         <= r_d;
            hit_q       <= hit_d;
            code_q      <= code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign kif.row       = ~(4'b0001 << r_q);
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_down  = key_down_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a modelled 4x4 matrix (SCAN_DIV=4, DEBOUNCE_FRAMES=3).
module tb_key_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] pressed = 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int wide     = 0;
    logic prev_valid = 1'b0;

    logic [3:0] row_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    key_scan_if kif ();

    key_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .kif (kif)
    );

    always #5 CLK = ~CLK;

    // col[c] low iff key (r,c) pressed on a row currently driven low
    always_comb begin
        kif.col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.row[r]) kif.col[c] = 1'b0;
    end

    always @(negedge CLK) begin
        if (kif.key_valid) pulses++;
        if (kif.key_valid && prev_valid) wide++;
        prev_valid = kif.key_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Leaves us on the negedge just after row 0 starts a fresh frame.
    task automatic align_frame();
        int guard = 0;
        while (kif.row != 4'h7 && guard < 40) begin @(negedge CLK); guard++; end
        while (kif.row == 4'h7 && guard < 40) begin @(negedge CLK); guard++; end
        if (guard >= 40) check("align_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle_scan(input string tag);
        for (int i = 0; i < 16; i++) begin
            check(tag, 32'(kif.row), 32'(row_seq[i/4]));
            @(negedge CLK);
        end
    endtask

    int p0;

    initial begin
        wait_cycles(3);
        check("rst_row",   32'(kif.row), 32'hE);
        check("rst_code",  32'(kif.key_code), 32'h0);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_down",  32'(kif.key_down), 32'h0);
        RST = 1'b0;
        idle_scan("idle_row");
        wait_cycles(50);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // single press, key 6
        p0 = pulses;
        pressed = 16'h0040;
        wait_cycles(67);
        check("press6_pulses", 32'(pulses - p0), 32'd1);
        check("press6_code", 32'(kif.key_code), 32'd6);
        check("press6_down", 32'(kif.key_down), 32'd1);
        wait_cycles(40);
        check("press6_hold_nopulse", 32'(pulses - p0), 32'd1);
        pressed = 16'h0000;
        wait_cycles(32);
        check("rel6_still_down", 32'(kif.key_down), 32'd1);
        wait_cycles(36);
        check("rel6_down", 32'(kif.key_down), 32'd0);
        check("rel6_nopulse", 32'(pulses - p0), 32'd1);

        // bounce: 2 hit frames, 1 empty, then stable
        align_frame();
        p0 = pulses;
        pressed = 16'h0040;
        wait_cycles(32);
        pressed = 16'h0000;
        wait_cycles(16);
        pressed = 16'h0040;
        wait_cycles(32);
        check("bounce_early", 32'(pulses - p0), 32'd0);
        wait_cycles(20);
        check("bounce_pulse", 32'(pulses - p0), 32'd1);
        check("bounce_code", 32'(kif.key_code), 32'd6);
        pressed = 16'h0000;
        wait_cycles(70);
        check("bounce_rel", 32'(kif.key_down), 32'd0);

        // simultaneous keys 5 and 9
        p0 = pulses;
        pressed = 16'h0220;
        wait_cycles(67);
        check("multi59_pulse", 32'(pulses - p0), 32'd1);
        check("multi59_code", 32'(kif.key_code), 32'd5);
        pressed = 16'h0000;
        wait_cycles(70);
        check("multi59_rel", 32'(kif.key_down), 32'd0);

        // simultaneous keys 3 and 2
        p0 = pulses;
        pressed = 16'h000C;
        wait_cycles(67);
        check("multi32_pulse", 32'(pulses - p0), 32'd1);
        check("multi32_code", 32'(kif.key_code), 32'd2);
        pressed = 16'h0000;
        wait_cycles(70);
        check("multi32_rel", 32'(kif.key_down), 32'd0);

        // key change while held: 3 then 12
        p0 = pulses;
        pressed = 16'h0008;
        wait_cycles(67);
        check("chg_pulse3", 32'(pulses - p0), 32'd1);
        check("chg_code3", 32'(kif.key_code), 32'd3);
        pressed = 16'h1000;
        wait_cycles(64);
        check("chg_nopulse", 32'(pulses - p0), 32'd1);
        check("chg_code_kept", 32'(kif.key_code), 32'd3);
        check("chg_down", 32'(kif.key_down), 32'd1);
        pressed = 16'h0000;
        wait_cycles(70);
        check("chg_rel", 32'(kif.key_down), 32'd0);

        // reset during press debounce
        align_frame();
        p0 = pulses;
        pressed = 16'h0040;
        wait_cycles(32);
        #2 RST = 1'b1;
        wait_cycles(2);
        RST = 1'b0;
        check("abort_nopulse", 32'(pulses - p0), 32'd0);
        wait_cycles(44);
        check("abort_fresh_early", 32'(pulses - p0), 32'd0);
        wait_cycles(8);
        check("abort_fresh_pulse", 32'(pulses - p0), 32'd1);
        check("abort_fresh_code", 32'(kif.key_code), 32'd6);

        // asynchronous reset with key held and accepted
        wait_cycles(5);
        check("pre_rst_down", 32'(kif.key_down), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("arst_row",   32'(kif.row), 32'hE);
        check("arst_code",  32'(kif.key_code), 32'h0);
        check("arst_valid", 32'(kif.key_valid), 32'h0);
        check("arst_down",  32'(kif.key_down), 32'h0);
        pressed = 16'h0000;
        @(negedge CLK);
        RST = 1'b0;
        p0 = pulses;
        idle_scan("arst_idle_row");
        wait_cycles(50);
        check("arst_idle_nopulse", 32'(pulses - p0), 32'd0);
        check("pulse_width", 32'(wide), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
